// File: rtl/txs_burst_writer.sv
// rtl/txs_burst_writer.sv - Avalon-MM burst master draining a 128-bit stream into a host ring buffer
// Stages words in a 2*BURST_LEN FIFO and issues fixed-length write bursts once a full burst is buffered.
module txs_burst_writer #(
    parameter int AW        = 22,
    parameter int BURST_LEN = 8,
    parameter int RING_LOG2 = 16
) (
    input  logic            c,
    input  logic            rst,
    input  logic            enable,
    input  logic [AW-1:0]   base_addr,
    input  logic [127:0]    in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [AW-1:0]   txs_address,
    output logic            txs_write,
    output logic [127:0]    txs_writedata,
    output logic [5:0]      txs_burstcount,
    input  logic            txs_waitrequest,
    output logic            irq,
    output logic [31:0]     burst_done
);

    localparam int DEPTH = 2 * BURST_LEN;
    localparam int PW    = $clog2(DEPTH);
    localparam int FW    = PW + 1;
    localparam int BCW   = $clog2(BURST_LEN) + 1;

    localparam logic [FW-1:0]        FILL_FULL   = FW'(DEPTH);
    localparam logic [FW-1:0]        FILL_BURST  = FW'(BURST_LEN);
    localparam logic [BCW-1:0]       LAST_BEAT   = BCW'(BURST_LEN - 1);
    // Truncates to 0 when one burst spans the whole ring, which is the correct wrap.
    localparam logic [RING_LOG2-1:0] BURST_BYTES = RING_LOG2'(BURST_LEN * 16);
    localparam logic [AW-1:0]        RING_MASK   = AW'((64'd1 << RING_LOG2) - 64'd1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [BCW-1:0]         beat_q, beat_d;
    logic [RING_LOG2-1:0]   offset_q, offset_d;
    logic [31:0]            done_q, done_d;
    logic                   irq_q, irq_d;
    logic [127:0]           mem_q [DEPTH];
    logic [127:0]           mem_d [DEPTH];

    logic push;
    logic pop;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        offset_d = offset_q;
        done_d   = done_q;
        irq_d    = 1'b0;
        mem_d    = mem_q;
        pop      = 1'b0;

        in_ready  = enable & (fill_q != FILL_FULL);
        txs_write = (state_q == S_BURST);
        push      = in_valid & in_ready;

        if (state_q == S_BURST && !txs_waitrequest) begin
            pop    = 1'b1;
            beat_d = beat_q + BCW'(1);
            if (beat_q == LAST_BEAT) begin
                state_d  = S_IDLE;
                beat_d   = '0;
                offset_d = offset_q + BURST_BYTES;
                done_d   = done_q + 32'd1;
                irq_d    = (offset_d[RING_LOG2-2:0] == '0);
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        // Flush only from IDLE; push is already blocked because in_ready needs enable.
        if (state_q == S_IDLE) begin
            if (!enable) begin
                fill_d   = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                offset_d = '0;
            end else if (fill_q >= FILL_BURST) begin
                state_d = S_BURST;
            end
        end
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            offset_q <= '0;
            done_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            offset_q <= offset_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge c) begin
        mem_q <= mem_d;
    end

    assign txs_writedata  = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign txs_address    = (base_addr & ~RING_MASK) | AW'(offset_q);
    assign txs_burstcount = 6'(BURST_LEN);
    assign irq            = irq_q;
    assign burst_done     = done_q;

endmodule

// File: tb/tb_txs_burst_writer.sv
// tb/tb_txs_burst_writer.sv - randomized bench for txs_burst_writer against a queue-based ring model
module tb_txs_burst_writer;

    localparam int AW    = 22;
    localparam int BLEN  = 8;
    localparam int DEPTH = 16;
    localparam int RING  = 65536;

    logic          c = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] base_addr = 22'h1ABCD;
    logic [127:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] txs_address;
    logic          txs_write;
    logic [127:0]  txs_writedata;
    logic [5:0]    txs_burstcount;
    logic          txs_waitrequest = 1'b0;
    logic          irq;
    logic [31:0]   burst_done;

    txs_burst_writer #(.AW(AW), .BURST_LEN(BLEN), .RING_LOG2(16)) dut (
        .c               (c),
        .rst             (rst),
        .enable          (enable),
        .base_addr       (base_addr),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .txs_address     (txs_address),
        .txs_write       (txs_write),
        .txs_writedata   (txs_writedata),
        .txs_burstcount  (txs_burstcount),
        .txs_waitrequest (txs_waitrequest),
        .irq             (irq),
        .burst_done      (burst_done)
    );

    always #5 c = ~c;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] q[$];
    bit           m_busy;
    int           m_beats;
    int           m_off;
    int           m_done;
    bit           m_irq;
    int           irq_seen;
    int           push_cnt;
    int           data_ctr;
    bit           rand_data;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic m_reset();
        q.delete();
        m_busy  = 0;
        m_beats = 0;
        m_off   = 0;
        m_done  = 0;
        m_irq   = 0;
    endtask

    function automatic logic [AW-1:0] exp_addr();
        return (base_addr & ~22'h00FFFF) | AW'(m_off);
    endfunction

    // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        bit acc;
        @(negedge c);
        check_eq("txs_write", txs_write, m_busy);
        check_eq("in_ready", in_ready, enable && q.size() < DEPTH);
        check_eq("irq", irq, m_irq);
        check_eq("burst_done", burst_done, m_done);
        check_eq("burstcount", txs_burstcount, BLEN);
        if (m_busy) begin
            check_eq("address", txs_address, exp_addr());
            check_eq("writedata", txs_writedata, q[0]);
        end
        if (irq) irq_seen++;
        if (!rst) begin
            acc   = in_valid && enable && q.size() < DEPTH;
            m_irq = 0;
            if (m_busy) begin
                if (!txs_waitrequest) begin
                    void'(q.pop_front());
                    m_beats++;
                    if (m_beats == BLEN) begin
                        m_busy  = 0;
                        m_beats = 0;
                        m_off   = (m_off + BLEN * 16) % RING;
                        m_done++;
                        m_irq   = (m_off % (RING / 2)) == 0;
                    end
                end
            end else if (!enable) begin
                q.delete();
                m_off = 0;
            end else if (q.size() >= BLEN) begin
                m_busy = 1;
            end
            if (acc) begin
                q.push_back(in_data);
                push_cnt++;
                data_ctr++;
            end
        end
        @(posedge c);
        #1;
    endtask

    task automatic drive(input bit v, input bit w);
        in_valid        = v;
        in_data         = rand_data ? {$urandom, $urandom, $urandom, $urandom} : 128'(data_ctr);
        txs_waitrequest = w;
        step();
    endtask

    task automatic run(input int n, input int limit, input int vpct, input int wpct);
        push_cnt = 0;
        for (int i = 0; i < n; i++)
            drive((push_cnt < limit) && ($urandom_range(99) < vpct), $urandom_range(99) < wpct);
    endtask

    task automatic pulse_reset();
        enable = 0;
        rst    = 1;
        m_reset();
        drive(0, 0);
        drive(0, 0);
        rst = 0;
        drive(0, 0);
    endtask

    initial begin
        m_reset();
        irq_seen  = 0;
        data_ctr  = 0;
        rand_data = 0;
        repeat (2) @(posedge c);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_write", txs_write, 0);
        check_eq("rst_irq", irq, 0);
        check_eq("rst_done", burst_done, 0);
        check_eq("rst_addr", txs_address, 22'h10000);
        check_eq("rst_wdata", txs_writedata, 0);
        check_eq("rst_bcount", txs_burstcount, 8);
        rst = 0;
        drive(0, 0);

        // single burst of 0..7
        base_addr = 22'h10000;
        enable    = 1;
        data_ctr  = 0;
        run(20, 8, 100, 0);
        check_eq("single_done", burst_done, 1);
        check_eq("single_noirq", irq_seen, 0);

        // random stalls, first beat included
        rand_data = 1;
        run(60, 8, 100, 40);
        check_eq("stall_done", burst_done, 2);

        // threshold: 7 words never start a burst
        run(57, 7, 100, 0);
        check_eq("thresh_hold", burst_done, 2);
        run(1, 1, 100, 0);
        drive(0, 0);
        check_eq("thresh_rise", txs_write, 1);
        run(20, 0, 0, 0);

        // 513 bursts across the ring
        pulse_reset();
        enable   = 1;
        irq_seen = 0;
        run(513 * 9 + 40, 513 * 8, 100, 0);
        check_eq("wrap_done", burst_done, 513);
        check_eq("wrap_irqs", irq_seen, 2);

        // full FIFO under a permanent stall
        enable = 0;
        drive(0, 0);
        enable = 1;
        run(40, 1000, 100, 100);
        check_eq("full_count", push_cnt, 16);
        check_eq("full_ready", in_ready, 0);
        run(40, 1000, 100, 0);
        run(30, 0, 0, 0);

        // enable dropped at beat 3
        enable = 0;
        drive(0, 0);
        enable = 1;
        for (int k = 0; k < 60 && !(m_busy && m_beats == 3); k++) drive(1, 0);
        check_eq("reach_beat3", m_busy && m_beats == 3, 1);
        enable = 0;
        run(15, 0, 0, 0);
        enable = 1;
        run(30, 8, 100, 0);

        // random traffic with base changes while disabled
        for (int seg = 0; seg < 15; seg++) begin
            if ($urandom_range(3) == 0) begin
                enable = 0;
                for (int k = 0; k < 200 && m_busy; k++) drive(0, $urandom_range(1));
                drive(0, 0);
                base_addr = AW'($urandom);
                enable    = 1;
            end
            run(100, 1 << 30, $urandom_range(100, 30), $urandom_range(60));
        end

        // asynchronous reset at beat 4
        enable = 1;
        for (int k = 0; k < 200 && !(m_busy && m_beats == 4); k++) drive(1, 0);
        check_eq("reach_beat4", m_busy && m_beats == 4, 1);
        rst = 1;
        #1;
        check_eq("async_write", txs_write, 0);
        check_eq("async_done", burst_done, 0);
        m_reset();
        enable = 0;
        drive(0, 0);
        rst = 0;
        drive(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
